// File: rtl/mem_arbiter_pkg.sv
// Shared types and helpers for the two-master memory arbiter.
package mem_arbiter_pkg;

  // Default port widths for the RISC-V core memory interfaces.
  localparam int RISCV_ADDR_WIDTH = 32;
  localparam int RISCV_WORD_WIDTH = 32;

  // Arbiter FSM encodings: idle, instruction fetch granted, data access granted.
  typedef enum logic [1:0] {
    ARB_IDLE  = 2'b00,
    ARB_GNT_I = 2'b01,
    ARB_GNT_D = 2'b10
  } arb_state_e;

  // Identity of the master served most recently.
  typedef enum logic {
    LAST_I = 1'b0,
    LAST_D = 1'b1
  } arb_master_e;

  // The "last served" history resets to the master that should lose a first-cycle tie.
  function automatic arb_master_e tie_loser(input logic dmem_first);
    return dmem_first ? LAST_I : LAST_D;
  endfunction

endpackage

// File: rtl/mem_arbiter_arb_mux.sv
// Combinational request mux: forwards the granted master's addr/wdata/we, zeros when idle.
module arb_mux
  import mem_arbiter_pkg::*;
#(
  parameter int ADDR_WIDTH = RISCV_ADDR_WIDTH,
  parameter int DATA_WIDTH = RISCV_WORD_WIDTH
) (
  input  arb_state_e            state_i,
  input  logic [ADDR_WIDTH-1:0] imem_addr_i,
  input  logic [DATA_WIDTH-1:0] imem_wdata_i,
  input  logic [3:0]            imem_we_i,
  input  logic [ADDR_WIDTH-1:0] dmem_addr_i,
  input  logic [DATA_WIDTH-1:0] dmem_wdata_i,
  input  logic [3:0]            dmem_we_i,
  output logic [ADDR_WIDTH-1:0] mem_addr_o,
  output logic [DATA_WIDTH-1:0] mem_wdata_o,
  output logic [3:0]            mem_we_o
);

  // Select the request fields of whichever master currently holds the grant.
  always_comb begin
    mem_addr_o  = '0;
    mem_wdata_o = '0;
    mem_we_o    = '0;
    case (state_i)
      ARB_GNT_I: begin
        mem_addr_o  = imem_addr_i;
        mem_wdata_o = imem_wdata_i;
        mem_we_o    = imem_we_i;
      end
      ARB_GNT_D: begin
        mem_addr_o  = dmem_addr_i;
        mem_wdata_o = dmem_wdata_i;
        mem_we_o    = dmem_we_i;
      end
      default: ;
    endcase
  end

endmodule

// File: rtl/mem_arbiter.sv
// Round-robin arbiter sharing one memory port between instruction fetch and data masters.
module mem_arbiter
  import mem_arbiter_pkg::*;
#(
  parameter int ADDR_WIDTH = RISCV_ADDR_WIDTH,
  parameter int DATA_WIDTH = RISCV_WORD_WIDTH,
  parameter int DMEM_FIRST = 1
) (
  input  logic                  clk,
  input  logic                  rst_n,
  input  logic                  imem_valid_i,
  output logic                  imem_ready_o,
  input  logic [ADDR_WIDTH-1:0] imem_addr_i,
  input  logic [DATA_WIDTH-1:0] imem_wdata_i,
  input  logic [3:0]            imem_we_i,
  output logic [DATA_WIDTH-1:0] imem_rdata_o,
  input  logic                  dmem_valid_i,
  output logic                  dmem_ready_o,
  input  logic [ADDR_WIDTH-1:0] dmem_addr_i,
  input  logic [DATA_WIDTH-1:0] dmem_wdata_i,
  input  logic [3:0]            dmem_we_i,
  output logic [DATA_WIDTH-1:0] dmem_rdata_o,
  output logic                  mem_valid_o,
  input  logic                  mem_ready_i,
  output logic [ADDR_WIDTH-1:0] mem_addr_o,
  output logic [DATA_WIDTH-1:0] mem_wdata_o,
  output logic [3:0]            mem_we_o,
  input  logic [DATA_WIDTH-1:0] mem_rdata_i
);

  localparam arb_master_e LAST_RESET = tie_loser(DMEM_FIRST != 0);

  arb_state_e  state_q, state_d;
  arb_master_e last_q, last_d;

  // Grant state and service history; reset drops any in-flight transaction.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q <= ARB_IDLE;
      last_q  <= LAST_RESET;
    end else begin
      state_q <= state_d;
      last_q  <= last_d;
    end
  end

  // Next grant and per-master handshakes; the owner's own valid on completion is ignored.
  always_comb begin
    state_d      = state_q;
    last_d       = last_q;
    mem_valid_o  = 1'b0;
    imem_ready_o = 1'b0;
    dmem_ready_o = 1'b0;
    case (state_q)
      ARB_IDLE: begin
        if (imem_valid_i && dmem_valid_i) begin
          state_d = (last_q == LAST_I) ? ARB_GNT_D : ARB_GNT_I;
        end else if (imem_valid_i) begin
          state_d = ARB_GNT_I;
        end else if (dmem_valid_i) begin
          state_d = ARB_GNT_D;
        end
      end
      ARB_GNT_I: begin
        mem_valid_o  = 1'b1;
        imem_ready_o = mem_ready_i;
        if (mem_ready_i) begin
          last_d  = LAST_I;
          state_d = dmem_valid_i ? ARB_GNT_D : ARB_IDLE;
        end
      end
      ARB_GNT_D: begin
        mem_valid_o  = 1'b1;
        dmem_ready_o = mem_ready_i;
        if (mem_ready_i) begin
          last_d  = LAST_D;
          state_d = imem_valid_i ? ARB_GNT_I : ARB_IDLE;
        end
      end
      default: begin
        state_d = ARB_IDLE;
      end
    endcase
  end

  // Read data fans out to both masters; only the one seeing ready consumes it.
  assign imem_rdata_o = mem_rdata_i;
  assign dmem_rdata_o = mem_rdata_i;

  arb_mux #(
    .ADDR_WIDTH(ADDR_WIDTH),
    .DATA_WIDTH(DATA_WIDTH)
  ) u_arb_mux (
    .state_i     (state_q),
    .imem_addr_i (imem_addr_i),
    .imem_wdata_i(imem_wdata_i),
    .imem_we_i   (imem_we_i),
    .dmem_addr_i (dmem_addr_i),
    .dmem_wdata_i(dmem_wdata_i),
    .dmem_we_i   (dmem_we_i),
    .mem_addr_o  (mem_addr_o),
    .mem_wdata_o (mem_wdata_o),
    .mem_we_o    (mem_we_o)
  );

endmodule

// File: tb/tb_mem_arbiter.sv
// Directed self-checking bench for mem_arbiter.
module tb_mem_arbiter;

  logic        clk = 1'b0;
  logic        rst_n;
  logic        imem_valid_i, imem_ready_o;
  logic [31:0] imem_addr_i, imem_wdata_i, imem_rdata_o;
  logic [3:0]  imem_we_i;
  logic        dmem_valid_i, dmem_ready_o;
  logic [31:0] dmem_addr_i, dmem_wdata_i, dmem_rdata_o;
  logic [3:0]  dmem_we_i;
  logic        mem_valid_o, mem_ready_i;
  logic [31:0] mem_addr_o, mem_wdata_o, mem_rdata_i;
  logic [3:0]  mem_we_o;

  int tests_run    = 0;
  int tests_failed = 0;

  mem_arbiter #(
    .ADDR_WIDTH(32),
    .DATA_WIDTH(32),
    .DMEM_FIRST(1)
  ) dut (
    .clk         (clk),
    .rst_n       (rst_n),
    .imem_valid_i(imem_valid_i),
    .imem_ready_o(imem_ready_o),
    .imem_addr_i (imem_addr_i),
    .imem_wdata_i(imem_wdata_i),
    .imem_we_i   (imem_we_i),
    .imem_rdata_o(imem_rdata_o),
    .dmem_valid_i(dmem_valid_i),
    .dmem_ready_o(dmem_ready_o),
    .dmem_addr_i (dmem_addr_i),
    .dmem_wdata_i(dmem_wdata_i),
    .dmem_we_i   (dmem_we_i),
    .dmem_rdata_o(dmem_rdata_o),
    .mem_valid_o (mem_valid_o),
    .mem_ready_i (mem_ready_i),
    .mem_addr_o  (mem_addr_o),
    .mem_wdata_o (mem_wdata_o),
    .mem_we_o    (mem_we_o),
    .mem_rdata_i (mem_rdata_i)
  );

  // 10 ns clock.
  always #5 clk = ~clk;

  // Master protocol watchdog: a pending request must keep valid asserted until ready.
  logic i_pend = 1'b0;
  logic d_pend = 1'b0;
  always @(negedge clk) begin
    if (!rst_n) begin
      i_pend = 1'b0;
      d_pend = 1'b0;
    end else begin
      assert (!(i_pend && !imem_valid_i)) else $error("[TB] imem dropped valid before ready");
      assert (!(d_pend && !dmem_valid_i)) else $error("[TB] dmem dropped valid before ready");
      i_pend = imem_valid_i && !imem_ready_o;
      d_pend = dmem_valid_i && !dmem_ready_o;
    end
  end

  // Each cycle: inputs change 1 ns after the rising edge, outputs are checked 2 ns later.
  task automatic next_cycle();
    @(posedge clk);
    #1;
  endtask

  task automatic clear_inputs();
    imem_valid_i = 1'b0; imem_addr_i = '0; imem_wdata_i = '0; imem_we_i = '0;
    dmem_valid_i = 1'b0; dmem_addr_i = '0; dmem_wdata_i = '0; dmem_we_i = '0;
    mem_ready_i  = 1'b0; mem_rdata_i = '0;
  endtask

  task automatic do_reset();
    next_cycle();
    rst_n = 1'b0;
    clear_inputs();
    next_cycle();
    next_cycle();
    rst_n = 1'b1;
  endtask

  // Outputs held at zero while reset is low, even with both masters and memory active.
  task automatic test_reset();
    rst_n = 1'b0;
    clear_inputs();
    imem_valid_i = 1'b1; imem_addr_i = 32'h0000_1234; imem_we_i = 4'hF; imem_wdata_i = 32'h5555_AAAA;
    dmem_valid_i = 1'b1; dmem_addr_i = 32'h0000_5678; dmem_we_i = 4'h3; dmem_wdata_i = 32'hAAAA_5555;
    mem_ready_i  = 1'b1;
    for (int c = 0; c < 3; c++) begin
      next_cycle();
      #2;
      tests_run++;
      if ({mem_valid_o, imem_ready_o, dmem_ready_o} !== 3'b000) begin
        tests_failed++;
        $display("[TB] FAIL reset_handshake c%0d: got mv/ir/dr=%b want 000", c, {mem_valid_o, imem_ready_o, dmem_ready_o});
      end
      tests_run++;
      if ({mem_addr_o, mem_wdata_o, mem_we_o} !== 68'h0) begin
        tests_failed++;
        $display("[TB] FAIL reset_bus c%0d: got addr=%h wdata=%h we=%h want zeros", c, mem_addr_o, mem_wdata_o, mem_we_o);
      end
    end
    next_cycle();
    clear_inputs();
    next_cycle();
    rst_n = 1'b1;
  endtask

  // One fetch: request cycle 0, grant cycles 1-2, memory ready in cycle 2.
  task automatic test_single_fetch();
    logic [3:0]  exp_mv = 4'b0110;
    logic [3:0]  exp_ir = 4'b0100;
    logic [31:0] exp_addr;
    for (int c = 0; c < 4; c++) begin
      next_cycle();
      imem_valid_i = (c <= 2);
      imem_addr_i  = 32'h0000_0100;
      dmem_addr_i  = 32'h0000_0F00;
      mem_ready_i  = (c == 2);
      mem_rdata_i  = (c == 2) ? 32'hDEAD_BEEF : 32'h1111_1111;
      #2;
      exp_addr = exp_mv[c] ? 32'h0000_0100 : 32'h0;
      tests_run++;
      if (mem_valid_o !== exp_mv[c]) begin
        tests_failed++;
        $display("[TB] FAIL fetch_mem_valid c%0d: got %b want %b", c, mem_valid_o, exp_mv[c]);
      end
      tests_run++;
      if (mem_addr_o !== exp_addr) begin
        tests_failed++;
        $display("[TB] FAIL fetch_mem_addr c%0d: got %h want %h", c, mem_addr_o, exp_addr);
      end
      tests_run++;
      if ({imem_ready_o, dmem_ready_o} !== {exp_ir[c], 1'b0}) begin
        tests_failed++;
        $display("[TB] FAIL fetch_readys c%0d: got ir/dr=%b%b want %b0", c, imem_ready_o, dmem_ready_o, exp_ir[c]);
      end
      if (c == 2) begin
        tests_run++;
        if (imem_rdata_o !== 32'hDEAD_BEEF || dmem_rdata_o !== 32'hDEAD_BEEF) begin
          tests_failed++;
          $display("[TB] FAIL fetch_rdata: got i=%h d=%h want deadbeef", imem_rdata_o, dmem_rdata_o);
        end
      end
    end
  endtask

  // Both masters request out of reset with zero-wait memory: dmem first, imem next, no bubble.
  task automatic test_simultaneous();
    logic [3:0]  exp_mv = 4'b0110;
    logic [3:0]  exp_dr = 4'b0010;
    logic [3:0]  exp_ir = 4'b0100;
    logic [31:0] exp_addr;
    do_reset();
    for (int c = 0; c < 4; c++) begin
      if (c > 0) next_cycle();
      imem_valid_i = (c <= 2); imem_addr_i = 32'h0000_0400;
      dmem_valid_i = (c <= 1); dmem_addr_i = 32'h0000_0800;
      mem_ready_i  = 1'b1;
      #2;
      exp_addr = (c == 1) ? 32'h0000_0800 : (c == 2) ? 32'h0000_0400 : 32'h0;
      tests_run++;
      if (mem_valid_o !== exp_mv[c]) begin
        tests_failed++;
        $display("[TB] FAIL simul_mem_valid c%0d: got %b want %b", c, mem_valid_o, exp_mv[c]);
      end
      tests_run++;
      if (mem_addr_o !== exp_addr) begin
        tests_failed++;
        $display("[TB] FAIL simul_mem_addr c%0d: got %h want %h", c, mem_addr_o, exp_addr);
      end
      tests_run++;
      if ({imem_ready_o, dmem_ready_o} !== {exp_ir[c], exp_dr[c]}) begin
        tests_failed++;
        $display("[TB] FAIL simul_readys c%0d: got ir/dr=%b%b want %b%b", c, imem_ready_o, dmem_ready_o, exp_ir[c], exp_dr[c]);
      end
    end
    clear_inputs();
  endtask

  // Both masters stream 10 requests each; wait states (3k+1)%4. History says imem was last, so dmem leads.
  task automatic test_contention();
    int          i_done = 0;
    int          d_done = 0;
    int          w;
    logic        owner_d = 1'b1;
    logic        last_cyc;
    logic [31:0] exp_addr;
    next_cycle();
    imem_valid_i = 1'b1; imem_addr_i = 32'h0000_1000; imem_we_i = 4'h0;
    dmem_valid_i = 1'b1; dmem_addr_i = 32'h0000_2000; dmem_we_i = 4'hF;
    mem_ready_i  = 1'b0;
    #2;
    tests_run++;
    if (mem_valid_o !== 1'b0) begin
      tests_failed++;
      $display("[TB] FAIL cont_idle_start: got mem_valid=%b want 0", mem_valid_o);
    end
    for (int k = 0; k < 20; k++) begin
      w = (k * 3 + 1) % 4;
      for (int j = 0; j <= w; j++) begin
        next_cycle();
        imem_valid_i = (i_done < 10);
        dmem_valid_i = (d_done < 10);
        imem_addr_i  = 32'(32'h1000 + 4 * i_done);
        dmem_addr_i  = 32'(32'h2000 + 4 * d_done);
        dmem_wdata_i = 32'(32'hD000_0000 + d_done);
        mem_ready_i  = (j == w);
        mem_rdata_i  = 32'(32'hC000_0000 + k);
        #2;
        last_cyc = (j == w);
        exp_addr = owner_d ? 32'(32'h2000 + 4 * d_done) : 32'(32'h1000 + 4 * i_done);
        tests_run++;
        if (mem_valid_o !== 1'b1 || mem_addr_o !== exp_addr) begin
          tests_failed++;
          $display("[TB] FAIL cont_grant k%0d j%0d: got mv=%b addr=%h want 1 %h", k, j, mem_valid_o, mem_addr_o, exp_addr);
        end
        tests_run++;
        if (mem_we_o !== (owner_d ? 4'hF : 4'h0)) begin
          tests_failed++;
          $display("[TB] FAIL cont_we k%0d j%0d: got %h want %h", k, j, mem_we_o, owner_d ? 4'hF : 4'h0);
        end
        tests_run++;
        if ({imem_ready_o, dmem_ready_o} !== {!owner_d && last_cyc, owner_d && last_cyc}) begin
          tests_failed++;
          $display("[TB] FAIL cont_readys k%0d j%0d: got ir/dr=%b%b want %b%b", k, j, imem_ready_o, dmem_ready_o,
                   !owner_d && last_cyc, owner_d && last_cyc);
        end
        if (last_cyc) begin
          tests_run++;
          if ((owner_d ? dmem_rdata_o : imem_rdata_o) !== 32'(32'hC000_0000 + k)) begin
            tests_failed++;
            $display("[TB] FAIL cont_rdata k%0d: got %h want %h", k, owner_d ? dmem_rdata_o : imem_rdata_o, 32'(32'hC000_0000 + k));
          end
        end
      end
      if (owner_d) d_done++; else i_done++;
      owner_d = !owner_d;
    end
    next_cycle();
    imem_valid_i = (i_done < 10);
    dmem_valid_i = (d_done < 10);
    mem_ready_i  = 1'b0;
    #2;
    tests_run++;
    if (mem_valid_o !== 1'b0) begin
      tests_failed++;
      $display("[TB] FAIL cont_idle_end: got mem_valid=%b want 0", mem_valid_o);
    end
    clear_inputs();
  endtask

  // Byte store with 3 wait states: request fields stay stable across all 4 grant cycles.
  task automatic test_byte_store();
    for (int c = 0; c < 6; c++) begin
      next_cycle();
      dmem_valid_i = (c <= 4);
      dmem_addr_i  = 32'h0000_2004; dmem_wdata_i = 32'h0000_AB00; dmem_we_i = 4'b0010;
      imem_addr_i  = 32'h0000_7770; imem_wdata_i = 32'hFFFF_FFFF; imem_we_i = 4'b1101;
      mem_ready_i  = (c == 4);
      #2;
      tests_run++;
      if (mem_valid_o !== (c >= 1 && c <= 4)) begin
        tests_failed++;
        $display("[TB] FAIL store_mem_valid c%0d: got %b want %b", c, mem_valid_o, (c >= 1 && c <= 4));
      end
      if (c >= 1 && c <= 4) begin
        tests_run++;
        if (mem_addr_o !== 32'h0000_2004 || mem_wdata_o !== 32'h0000_AB00 || mem_we_o !== 4'b0010) begin
          tests_failed++;
          $display("[TB] FAIL store_fields c%0d: got addr=%h wdata=%h we=%b want 00002004 0000ab00 0010", c, mem_addr_o, mem_wdata_o, mem_we_o);
        end
      end else begin
        tests_run++;
        if ({mem_addr_o, mem_wdata_o, mem_we_o} !== 68'h0) begin
          tests_failed++;
          $display("[TB] FAIL store_idle_bus c%0d: got addr=%h wdata=%h we=%b want zeros", c, mem_addr_o, mem_wdata_o, mem_we_o);
        end
      end
      tests_run++;
      if ({imem_ready_o, dmem_ready_o} !== {1'b0, c == 4}) begin
        tests_failed++;
        $display("[TB] FAIL store_readys c%0d: got ir/dr=%b%b want 0%b", c, imem_ready_o, dmem_ready_o, c == 4);
      end
    end
    clear_inputs();
  endtask

  // Reset asserted during a stalled dmem grant, then a fresh fetch after release.
  task automatic test_reset_mid();
    next_cycle();
    dmem_valid_i = 1'b1; dmem_addr_i = 32'h0000_3000; dmem_wdata_i = 32'h1234_5678; dmem_we_i = 4'hF;
    mem_ready_i  = 1'b0;
    next_cycle();
    #2;
    tests_run++;
    if (mem_valid_o !== 1'b1 || mem_addr_o !== 32'h0000_3000) begin
      tests_failed++;
      $display("[TB] FAIL rmid_granted: got mv=%b addr=%h want 1 00003000", mem_valid_o, mem_addr_o);
    end
    rst_n = 1'b0;
    dmem_valid_i = 1'b0;
    mem_ready_i  = 1'b1;
    #1;
    tests_run++;
    if ({mem_valid_o, imem_ready_o, dmem_ready_o} !== 3'b000 || {mem_addr_o, mem_wdata_o, mem_we_o} !== 68'h0) begin
      tests_failed++;
      $display("[TB] FAIL rmid_async_clear: got mv/ir/dr=%b%b%b addr=%h wdata=%h we=%h want zeros",
               mem_valid_o, imem_ready_o, dmem_ready_o, mem_addr_o, mem_wdata_o, mem_we_o);
    end
    next_cycle();
    rst_n = 1'b1;
    for (int c = 0; c < 3; c++) begin
      if (c > 0) next_cycle();
      clear_inputs();
      imem_valid_i = (c <= 1);
      imem_addr_i  = 32'h0000_0500;
      mem_ready_i  = (c == 1);
      #2;
      tests_run++;
      if (mem_valid_o !== (c == 1) || imem_ready_o !== (c == 1) || dmem_ready_o !== 1'b0) begin
        tests_failed++;
        $display("[TB] FAIL rmid_refetch c%0d: got mv/ir/dr=%b%b%b want %b%b0", c, mem_valid_o, imem_ready_o, dmem_ready_o, c == 1, c == 1);
      end
      tests_run++;
      if (mem_addr_o !== ((c == 1) ? 32'h0000_0500 : 32'h0)) begin
        tests_failed++;
        $display("[TB] FAIL rmid_refetch_addr c%0d: got %h want %h", c, mem_addr_o, (c == 1) ? 32'h0000_0500 : 32'h0);
      end
    end
    clear_inputs();
  endtask

  // Three back-to-back fetches with zero-wait memory: one IDLE bubble between each.
  task automatic test_back_to_back();
    logic [31:0] exp_addr;
    for (int c = 0; c < 7; c++) begin
      next_cycle();
      imem_valid_i = (c <= 5);
      imem_addr_i  = 32'(32'h300 + 4 * (c / 2));
      mem_ready_i  = 1'b1;
      #2;
      exp_addr = (c % 2 == 1) ? 32'(32'h300 + 4 * (c / 2)) : 32'h0;
      tests_run++;
      if (mem_valid_o !== (c % 2 == 1) || imem_ready_o !== (c % 2 == 1) || dmem_ready_o !== 1'b0) begin
        tests_failed++;
        $display("[TB] FAIL b2b_pattern c%0d: got mv/ir/dr=%b%b%b want %b%b0", c, mem_valid_o, imem_ready_o, dmem_ready_o,
                 c % 2 == 1, c % 2 == 1);
      end
      tests_run++;
      if (mem_addr_o !== exp_addr) begin
        tests_failed++;
        $display("[TB] FAIL b2b_addr c%0d: got %h want %h", c, mem_addr_o, exp_addr);
      end
    end
    clear_inputs();
  endtask

  // Scenario sequence; contention relies on imem being the last master served by test_simultaneous.
  initial begin
    test_reset();
    test_single_fetch();
    test_simultaneous();
    test_contention();
    test_byte_store();
    test_reset_mid();
    test_back_to_back();
    next_cycle();
    $display("[TB] %0d tests run, %0d failed", tests_run, tests_failed);
    $finish;
  end

endmodule
